// File: rtl/fetch_control_pkg.sv
// fetch_control_pkg: shared ARM definitions for fetch control and execute.
// Holds the condition-code encodings, the fetch-control FSM state type,
// the branch opcode field value and a branch-target helper.
package fetch_control_pkg;
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;
  typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_SQUASH} state_e;
  localparam logic [2:0] BR_OP = 3'b101;
  // Word offset is sign-extended and scaled to bytes; PC reads two words ahead.
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [23:0] imm);
    return pc + 32'd8 + {{6{imm[23]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_control_cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV flags.
// Ports: cond_i (condition field), flags_i (N=3 Z=2 C=1 V=0), pass_o (condition holds).
// NV (4'hF) never passes.
module cond_check
  import fetch_control_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = !c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = !n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = !v;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = n == v;
      COND_LT: pass_o = n != v;
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      COND_AL: pass_o = 1'b1;
      default: pass_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/fetch_control.sv
// fetch_control: decode-stage latch with branch resolution, hold and squash control.
// Inputs : clk, rst (sync, active-high), PC_in/Instruction_in (fetched word),
//          Flags (NZCV), Flags_pending (flags not yet valid), Hazard (decode data hazard).
// Outputs: freeze (fetch hold), Branch_taken/BranchAddr (redirect), PC_out/Instruction_out/
//          Valid_out (latched decode instruction; Valid_out=0 marks a bubble).
// Optional BRANCH_LINK_EN adds Link_we/Link_value for BL (return address PC_out+4).
module fetch_control
  import fetch_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instruction_in,
  input  logic [3:0]  Flags,
  input  logic        Flags_pending,
  input  logic        Hazard,
  output logic        freeze,
  output logic        Branch_taken,
  output logic [31:0] BranchAddr,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction_out,
  output logic        Valid_out
`ifdef BRANCH_LINK_EN
  ,
  output logic        Link_we,
  output logic [31:0] Link_value
`endif
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        live, is_br, cond_pass, hold, taken;
  cond_check u_cond (
    .cond_i (instr_q[31:28]),
    .flags_i(Flags),
    .pass_o (cond_pass)
  );
  // A squashed bubble never drives control, whatever it happens to contain.
  assign live   = valid_q && state_q != ST_SQUASH;
  assign is_br  = live && instr_q[27:25] == BR_OP;
  // Only conditional branches need settled flags; AL resolves regardless.
  assign hold   = live && (Hazard || (is_br && cond_e'(instr_q[31:28]) != COND_AL && Flags_pending));
  assign taken  = is_br && cond_pass && !hold;
  assign freeze          = hold;
  assign Branch_taken    = taken;
  assign BranchAddr      = br_target(pc_q, instr_q[23:0]);
  assign PC_out          = pc_q;
  assign Instruction_out = instr_q;
  assign Valid_out       = valid_q;
`ifdef BRANCH_LINK_EN
  assign Link_we    = taken && instr_q[24];
  assign Link_value = pc_q + 32'd4;
`endif
  always_comb begin
    state_d = hold ? ST_HOLD : taken ? ST_SQUASH : ST_RUN;
    pc_d    = hold ? pc_q : PC_in;
    instr_d = hold ? instr_q : Instruction_in;
    valid_d = hold ? valid_q : !taken;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_fetch_control.sv
// tb_fetch_control: directed and randomized checks of fetch_control against a behavioural model.
module tb_fetch_control;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_in = '0, Instruction_in = '0;
  logic [3:0]  Flags = '0;
  logic        Flags_pending = 1'b0, Hazard = 1'b0;
  logic        freeze, Branch_taken, Valid_out;
  logic [31:0] BranchAddr, PC_out, Instruction_out;
`ifdef BRANCH_LINK_EN
  logic        Link_we;
  logic [31:0] Link_value;
`endif
  int n_tests = 0, n_fail = 0;
  localparam logic [31:0] NOP = 32'hE1A00000;

  fetch_control dut (
    .clk(clk), .rst(rst), .PC_in(PC_in), .Instruction_in(Instruction_in),
    .Flags(Flags), .Flags_pending(Flags_pending), .Hazard(Hazard),
    .freeze(freeze), .Branch_taken(Branch_taken), .BranchAddr(BranchAddr),
    .PC_out(PC_out), .Instruction_out(Instruction_out), .Valid_out(Valid_out)
`ifdef BRANCH_LINK_EN
    , .Link_we(Link_we), .Link_value(Link_value)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ARM rule: cond[3:1] selects a base test, cond[0] inverts it; 111x is AL / never.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] && !f[2];
      3'd5: b = f[3] == f[0];
      3'd6: b = !f[2] && (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  // Model: what decode holds, and what control must do with it this cycle.
  bit          m_known = 0, m_valid = 0;
  logic [31:0] m_pc = '0, m_ins = '0;
  always begin
    bit br, e_frz, e_tk, n_valid;
    logic [31:0] e_addr, n_pc, n_ins;
    @(negedge clk);
    br     = m_valid && m_ins[27:25] == 3'b101;
    e_frz  = m_valid && (Hazard || (br && m_ins[31:28] != 4'hE && Flags_pending));
    e_tk   = br && cond_ok(m_ins[31:28], Flags) && !e_frz;
    e_addr = m_pc + 32'd8 + 32'($signed(m_ins[23:0])) * 4;
    if (m_known) begin
      chk("m:Valid_out", {31'd0, Valid_out}, {31'd0, m_valid});
      chk("m:PC_out", PC_out, m_pc);
      chk("m:Instruction_out", Instruction_out, m_ins);
      chk("m:freeze", {31'd0, freeze}, {31'd0, e_frz});
      chk("m:Branch_taken", {31'd0, Branch_taken}, {31'd0, e_tk});
      if (br) chk("m:BranchAddr", BranchAddr, e_addr);
`ifdef BRANCH_LINK_EN
      chk("m:Link_we", {31'd0, Link_we}, {31'd0, e_tk && m_ins[24]});
      if (e_tk && m_ins[24]) chk("m:Link_value", Link_value, m_pc + 32'd4);
`endif
    end
    n_valid = e_frz ? m_valid : !e_tk;
    n_pc    = e_frz ? m_pc : PC_in;
    n_ins   = e_frz ? m_ins : Instruction_in;
    if (rst) begin
      n_valid = 0;
      n_pc    = '0;
      n_ins   = '0;
    end
    @(posedge clk);
    if (rst) m_known = 1;
    m_valid = n_valid;
    m_pc    = n_pc;
    m_ins   = n_ins;
  end

  task automatic tick(input logic [31:0] pc, input logic [31:0] ins);
    @(posedge clk);
    #1;
    PC_in = pc;
    Instruction_in = ins;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    PC_in = 32'h0;
    Instruction_in = NOP;
    @(negedge clk);
    chk("reset Valid_out", {31'd0, Valid_out}, 32'd0);
    chk("reset freeze", {31'd0, freeze}, 32'd0);
    chk("reset Branch_taken", {31'd0, Branch_taken}, 32'd0);
    tick(32'h4, NOP);
    @(negedge clk);
    chk("post-reset Valid_out", {31'd0, Valid_out}, 32'd1);
    // Taken forward B
    tick(32'h10, 32'hEA000003);
    tick(32'h14, NOP);
    @(negedge clk);
    chk("B taken", {31'd0, Branch_taken}, 32'd1);
    chk("B addr", BranchAddr, 32'h24);
    tick(32'h24, NOP);
    @(negedge clk);
    chk("B bubble", {31'd0, Valid_out}, 32'd0);
    chk("B bubble taken", {31'd0, Branch_taken}, 32'd0);
    tick(32'h28, NOP);
    @(negedge clk);
    chk("B target PC", PC_out, 32'h24);
    // Not-taken BEQ
    Flags = 4'b0000;
    tick(32'h2C, 32'h0A000003);
    tick(32'h30, NOP);
    @(negedge clk);
    chk("BEQ not taken", {31'd0, Branch_taken}, 32'd0);
    tick(32'h34, NOP);
    @(negedge clk);
    chk("BEQ no bubble", {31'd0, Valid_out}, 32'd1);
    chk("BEQ straight PC", PC_out, 32'h30);
    // Backward wrap
    tick(32'h0, 32'hEAFFFFFD);
    tick(32'h4, NOP);
    @(negedge clk);
    chk("wrap taken", {31'd0, Branch_taken}, 32'd1);
    chk("wrap addr", BranchAddr, 32'hFFFFFFFC);
    tick(32'hFFFFFFFC, NOP);
    tick(32'h100, NOP);
    // Pending flags hold a BNE, then it resolves in the same cycle they settle
    Flags_pending = 1'b1;
    tick(32'h200, 32'h1A000001);
    tick(32'h204, NOP);
    @(negedge clk);
    chk("BNE hold freeze", {31'd0, freeze}, 32'd1);
    chk("BNE hold taken", {31'd0, Branch_taken}, 32'd0);
    tick(32'h208, NOP);
    @(negedge clk);
    chk("BNE hold 2 freeze", {31'd0, freeze}, 32'd1);
    chk("BNE hold latch", PC_out, 32'h200);
    tick(32'h208, NOP);
    Flags_pending = 1'b0;
    @(negedge clk);
    chk("BNE release taken", {31'd0, Branch_taken}, 32'd1);
    chk("BNE release freeze", {31'd0, freeze}, 32'd0);
    chk("BNE addr", BranchAddr, 32'h20C);
    tick(32'h20C, NOP);
    // Reset in the middle of a squash
    tick(32'h300, 32'hEA000000);
    tick(32'h304, NOP);
    @(negedge clk);
    chk("pre-rst taken", {31'd0, Branch_taken}, 32'd1);
    tick(32'h308, NOP);
    rst = 1'b1;
    @(negedge clk);
    chk("squash Valid_out", {31'd0, Valid_out}, 32'd0);
    tick(32'h0, NOP);
    rst = 1'b0;
    @(negedge clk);
    chk("rst-squash Valid_out", {31'd0, Valid_out}, 32'd0);
    chk("rst-squash taken", {31'd0, Branch_taken}, 32'd0);
    chk("rst-squash PC_out", PC_out, 32'h0);
    tick(32'h4, NOP);
    @(negedge clk);
    chk("rst-squash resume", {31'd0, Valid_out}, 32'd1);
    // Hazard holds even an unconditional branch
    tick(32'h400, 32'hEA000001);
    tick(32'h404, NOP);
    Hazard = 1'b1;
    @(negedge clk);
    chk("hazard freeze", {31'd0, freeze}, 32'd1);
    chk("hazard taken", {31'd0, Branch_taken}, 32'd0);
    tick(32'h404, NOP);
    Hazard = 1'b0;
    @(negedge clk);
    chk("hazard release taken", {31'd0, Branch_taken}, 32'd1);
    chk("hazard addr", BranchAddr, 32'h40C);
    // Randomized traffic checked by the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(1) == 1) ins[27:25] = 3'b101;
      tick({$urandom_range(32'h3FFF), 2'b00}, ins);
      Flags = 4'($urandom);
      Flags_pending = $urandom_range(3) == 0;
      Hazard = $urandom_range(6) == 0;
      rst = $urandom_range(40) == 0;
    end
    tick(32'h0, NOP);
    rst = 1'b0;
    Hazard = 1'b0;
    Flags_pending = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port PC_in  input  32  address of the instruction currently presented by fetch.
REQ-004 SHALL have port Instruction_in  input  32  instruction word at PC_in.
REQ-005 SHALL have port Flags  input  4  current NZCV status, N=bit3 .. V=bit0.
REQ-006 SHALL have port Flags_pending  input  1  a flag-setting instruction is in flight downstream; flags not yet valid.
REQ-007 SHALL have port Hazard  input  1  data hazard on the decode-stage instruction, from the hazard unit.
REQ-008 SHALL have port freeze  output  1  fetch hold request to the fetch stage.
REQ-009 SHALL have port Branch_taken  output  1  redirect fetch next edge.
REQ-010 SHALL have port BranchAddr  output  32  redirect target.
REQ-011 SHALL have ports PC_out, Instruction_out  output  32 each  decode-stage latched copy.
REQ-012 SHALL have port Valid_out  output  1  latched instruction is architecturally live (not a bubble).

Function
REQ-013 SHALL latch PC_in/Instruction_in into PC_out/Instruction_out on every edge unless holding (REQ-017).
REQ-014 SHALL recognise a branch when Valid_out=1 and Instruction_out[27:25]=3'b101; imm24=Instruction_out[23:0].
REQ-015 SHALL compute BranchAddr = PC_out + 8 + (sign_extend(imm24) << 2), modulo 2^32, combinationally from the latched registers.
REQ-016 SHALL evaluate cond=Instruction_out[31:28] per the ARM table (EQ..AL; 4'b1111 treated as never) against Flags.
REQ-017 SHALL hold (freeze=1, latch unchanged) when Valid_out=1 and (Hazard=1, or a branch with cond!=AL while Flags_pending=1).
REQ-018 SHALL assert Branch_taken=1 only for a recognised branch whose condition passes and when not holding; hold has priority over branch.
REQ-019 SHALL, on the edge where Branch_taken=1, latch the fetched wrong-path instruction with Valid_out=0 (squash); the redirected instruction is latched the following edge.
REQ-020 SHALL implement FSM RUN/HOLD/SQUASH: RUN->HOLD on hold condition; RUN->SQUASH on Branch_taken; HOLD->RUN when hold clears, with Branch_taken evaluated in that same RUN cycle; SQUASH->RUN unconditionally after one cycle.
REQ-021 SHALL never assert freeze or Branch_taken while Valid_out=0; in SQUASH both are 0 and the bubble's contents are ignored.
REQ-022 SHALL keep Branch_taken and freeze purely functions of registered state and current inputs (no extra latency); a taken branch costs exactly one bubble.

Reset
REQ-023 SHALL on rst=1 at an edge set PC_out=0, Instruction_out=0, Valid_out=0, state=RUN, irrespective of state (including mid-HOLD or mid-SQUASH).
REQ-024 SHALL drive freeze=0, Branch_taken=0 while Valid_out=0, hence in the first cycle after reset; BranchAddr=0+8+0=32'h8 is don't-care there.

Configuration
REQ-025 SHALL, with BRANCH_LINK_EN defined, add outputs Link_we (1) and Link_value (32): Link_we=1 and Link_value=PC_out+4 in the cycle Branch_taken=1 for an instruction with bit24=1 (BL); otherwise Link_we=0.
REQ-026 SHALL, without BRANCH_LINK_EN, omit these ports and treat BL exactly as B.

Structure
REQ-027 SHALL place condition-code encodings, the FSM state type and the branch opcode constant 3'b101 in the shared ARM package.
REQ-028 SHALL implement condition evaluation as sub-module cond_check (inputs cond, Flags; output pass), reusable by the execute stage.

Verification
REQ-029 Reset: rst=1 two cycles, then release -> Valid_out=0, freeze=0, Branch_taken=0 in first cycle; Valid_out=1 next cycle.
REQ-030 Taken forward B: PC_in=32'h10, Instruction_in=32'hEA000003 -> next cycle Branch_taken=1, BranchAddr=32'h24; following cycle Valid_out=0.
REQ-031 Not-taken: 32'h0A000003 (BEQ) with Flags=4'b0000 -> Branch_taken=0, no bubble, straight-line continues.
REQ-032 Backward wrap: PC_in=32'h0, 32'hEAFFFFFD -> BranchAddr=32'hFFFFFFFC (0+8-12 modulo 2^32).
REQ-033 Priority: BNE latched with Flags_pending=1 for 2 cycles -> freeze=1, Branch_taken=0, latch stable; pending drops with Z=0 -> Branch_taken=1 same cycle.
REQ-034 Reset mid-SQUASH: rst=1 on edge after Branch_taken -> state RUN, Valid_out=0, no spurious Branch_taken.
